// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard unit FSM state and register-file constants.
package cpu_types_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } hazard_state_t;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard unit bundle: pipeline status in, stage enables/flushes and status out.
interface hazard_control_if;
  import cpu_types_pkg::*;

  logic        ihit;
  logic        dhit;
  regbits_t    id_rs;
  regbits_t    id_rt;
  logic        id_uses_rt;
  logic        ex_dREN;
  regbits_t    ex_wsel;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic        mem_redirect;
  logic        wb_halt;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        pc_sel_redirect;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_wsel,
           mem_dREN, mem_dWEN, mem_redirect, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel_redirect, halted, stall_cycles
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_wsel,
           mem_dREN, mem_dWEN, mem_redirect, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel_redirect, halted, stall_cycles
  );

endinterface

// File: rtl/hazard_control_load_use_detect.sv
// Detects a decode-stage read of a register still being loaded in execute.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     load_use
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_dREN && (ex_wsel != REG_ZERO) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: prioritised stall/flush/redirect with halt FSM.
module hazard_control
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  hazard_control_if.slave   hif
);

  hazard_state_t state_reg, state_next;
  logic [15:0]   stall_reg, stall_next;
  logic          load_use;
  logic          mem_stall;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic pc_sel_redirect;

  load_use_detect u_load_use (
    .ex_dREN    (hif.ex_dREN),
    .ex_wsel    (hif.ex_wsel),
    .id_rs      (hif.id_rs),
    .id_rt      (hif.id_rt),
    .id_uses_rt (hif.id_uses_rt),
    .load_use   (load_use)
  );

  assign mem_stall = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;

  // Strict priority: only the highest active condition shapes the outputs.
  always_comb begin
    pc_en           = 1'b1;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    memwb_en        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    memwb_flush     = 1'b0;
    pc_sel_redirect = 1'b0;
    state_next      = state_reg;

    if (state_reg == HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (hif.wb_halt) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      state_next = HALTED;
    end else if (mem_stall) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      memwb_flush = 1'b1;
    end else if (hif.mem_redirect) begin
      pc_sel_redirect = 1'b1;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      exmem_flush     = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!hif.ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_next = stall_reg;
    if ((state_reg == RUN) && (!pc_en || pc_sel_redirect) && (stall_reg != STALL_CNT_MAX))
      stall_next = stall_reg + 16'd1;
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      stall_reg <= stall_next;
    end
  end

  assign hif.pc_en           = pc_en;
  assign hif.ifid_en         = ifid_en;
  assign hif.idex_en         = idex_en;
  assign hif.exmem_en        = exmem_en;
  assign hif.memwb_en        = memwb_en;
  assign hif.ifid_flush      = ifid_flush;
  assign hif.idex_flush      = idex_flush;
  assign hif.exmem_flush     = exmem_flush;
  assign hif.memwb_flush     = memwb_flush;
  assign hif.pc_sel_redirect = pc_sel_redirect;
  assign hif.halted          = (state_reg == HALTED);
  assign hif.stall_cycles    = stall_reg;

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench: stimulus queues hand-computed responses, a negedge monitor compares.
module tb_hazard_control;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  hazard_control_if hif();

  hazard_control dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hif  (hif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [4:0]  en;     // pc, ifid, idex, exmem, memwb
    logic [3:0]  fl;     // ifid, idex, exmem, memwb
    logic        sel;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Inputs: ihit dhit rs rt uses_rt ex_dREN ex_wsel mem_dREN mem_dWEN redirect wb_halt
  task automatic set_in(input logic ih, input logic dh, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic ldr,
                        input logic [4:0] ws, input logic mr, input logic mw,
                        input logic rd, input logic hl);
    hif.ihit = ih; hif.dhit = dh; hif.id_rs = rs; hif.id_rt = rt;
    hif.id_uses_rt = urt; hif.ex_dREN = ldr; hif.ex_wsel = ws;
    hif.mem_dREN = mr; hif.mem_dWEN = mw; hif.mem_redirect = rd; hif.wb_halt = hl;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] en, input logic [3:0] fl,
                            input logic sel, input logic hlt, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.en = en; e.fl = fl; e.sel = sel; e.halted = hlt; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // One cycle: drive just after posedge, queue expectation, hold until next posedge.
  task automatic vec(input string nm,
                     input logic ih, input logic dh, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt, input logic ldr,
                     input logic [4:0] ws, input logic mr, input logic mw,
                     input logic rd, input logic hl,
                     input logic [4:0] en, input logic [3:0] fl,
                     input logic sel, input logic hlt, input logic [15:0] cnt);
    @(posedge CLK); #1;
    set_in(ih, dh, rs, rt, urt, ldr, ws, mr, mw, rd, hl);
    expect_out(nm, en, fl, sel, hlt, cnt);
  endtask

  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] a_en;
      logic [3:0] a_fl;
      e = exp_q.pop_front();
      a_en = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en};
      a_fl = {hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush};
      checks++;
      if (a_en !== e.en || a_fl !== e.fl || hif.pc_sel_redirect !== e.sel ||
          hif.halted !== e.halted || hif.stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL %s: got en=%b fl=%b sel=%b halted=%b cnt=%h, want en=%b fl=%b sel=%b halted=%b cnt=%h",
                 e.name, a_en, a_fl, hif.pc_sel_redirect, hif.halted, hif.stall_cycles,
                 e.en, e.fl, e.sel, e.halted, e.cnt);
      end else begin
        $display("ok   %s: en=%b fl=%b sel=%b halted=%b cnt=%h",
                 e.name, a_en, a_fl, hif.pc_sel_redirect, hif.halted, hif.stall_cycles);
      end
    end
  end

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    expect_out("reset_state", 5'b11111, 4'b0000, 0, 0, 16'h0000);
    @(posedge CLK); #1;
    nRST = 1'b1;

    //   name           ih dh rs rt u  ld ws mr mw rd hl   en        fl      sel hlt cnt
    vec("default",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0, 16'd0);
    vec("load_use_rs",  1, 0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 5'b00111, 4'b0100, 0, 0, 16'd0);
    vec("load_to_r0",   1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0, 16'd1);
    vec("load_use_rt",  1, 0, 3, 7, 1, 1, 7, 0, 0, 0, 0, 5'b00111, 4'b0100, 0, 0, 16'd1);
    vec("rt_not_used",  1, 0, 3, 7, 0, 1, 7, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0, 16'd2);
    vec("redir_imiss",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 4'b1110, 1, 0, 16'd2);
    vec("redir_over_lu",1, 0, 9, 0, 0, 1, 9, 0, 0, 1, 0, 5'b11111, 4'b1110, 1, 0, 16'd3);
    vec("mstall_redir", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00001, 4'b0001, 0, 0, 16'd4);
    vec("mstall_wr_lu", 1, 0, 4, 0, 0, 1, 4, 0, 1, 0, 0, 5'b00001, 4'b0001, 0, 0, 16'd5);
    vec("dhit_imiss",   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b01111, 4'b1000, 0, 0, 16'd6);
    vec("lu_over_imiss",0, 0, 2, 0, 0, 1, 2, 0, 0, 0, 0, 5'b00111, 4'b0100, 0, 0, 16'd7);
    vec("halt_req",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5'b00000, 4'b0000, 0, 0, 16'd8);
    vec("halted",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 1, 16'd9);
    vec("halted_sticky",0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00000, 4'b0000, 0, 1, 16'd9);

    // Asynchronous reset mid-cycle while halted.
    @(posedge CLK); #1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    expect_out("async_reset", 5'b11111, 4'b0000, 0, 0, 16'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    vec("after_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0, 16'd0);

    // Reset during a stall abandons it.
    vec("stall_pre_rst",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 4'b1000, 0, 0, 16'd0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    expect_out("rst_in_stall", 5'b01111, 4'b1000, 0, 0, 16'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("run_after_rst", 5'b11111, 4'b0000, 0, 0, 16'd0);

    // Saturation: 65540 fetch-miss edges.
    @(posedge CLK); #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65540) @(posedge CLK);
    #1;
    expect_out("saturated", 5'b01111, 4'b1000, 0, 0, 16'hFFFF);
    vec("sat_hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 4'b1000, 0, 0, 16'hFFFF);
    vec("sat_halt_req", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 4'b0000, 0, 0, 16'hFFFF);
    vec("sat_halted",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 1, 16'hFFFF);

    @(posedge CLK); #1;
    @(posedge CLK); #1;
    stim_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
      end
      begin
        #2ms;
        $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
        errors++;
      end
    join_any
    disable fork;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 CLK  input  1  rising-edge clock.
REQ-002 nRST  input  1  reset, asynchronous, active-low.
REQ-003 ihit  input  1  instruction fetch completed this cycle.
REQ-004 dhit  input  1  data access in MEM completed this cycle.
REQ-005 id_rs  input  5  decode-stage source register rs.
REQ-006 id_rt  input  5  decode-stage source register rt.
REQ-007 id_uses_rt  input  1  decode instruction reads rt.
REQ-008 ex_dREN  input  1  execute-stage instruction is a load.
REQ-009 ex_wsel  input  5  execute-stage destination register.
REQ-010 mem_dREN, mem_dWEN  input  1 each  MEM-stage memory request.
REQ-011 mem_redirect  input  1  branch taken or jump resolved in MEM.
REQ-012 wb_halt  input  1  halt or overflow instruction in WB.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register update enables.
REQ-014 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load bubble (all-zero control) on enabled edge.
REQ-015 pc_sel_redirect  output  1  PC loads redirect target instead of PC+4.
REQ-016 halted  output  1  registered; processor stopped.
REQ-017 stall_cycles  output  16  registered stall performance counter.

Function
REQ-018 FSM states RUN and HALTED only; outputs otherwise combinational from state and inputs.
REQ-019 Default (no condition below applies): all enables 1, all flushes 0, pc_sel_redirect 0.
REQ-020 Conditions are evaluated in strict priority order, REQ-021 first; only the highest active condition applies.
REQ-021 HALTED: all enables 0, all flushes 0, pc_sel_redirect 0, halted 1; state is sticky until reset.
REQ-022 RUN with wb_halt=1: all enables 0; next state HALTED; halted goes to 1 on the following edge.
REQ-023 Memory stall, (mem_dREN|mem_dWEN)&~dhit: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_en=1 with memwb_flush=1.
REQ-024 Redirect, mem_redirect=1: pc_en=1 and pc_sel_redirect=1 regardless of ihit; ifid_flush, idex_flush and exmem_flush are 1; memwb advances normally.
REQ-025 Load-use, ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | id_uses_rt & ex_wsel==id_rt): pc_en=0 and ifid_en=0; idex_flush=1; remaining stages advance.
REQ-026 Fetch miss, ihit=0: pc_en=0 and ifid_flush=1; later stages advance.
REQ-027 Register $0 never causes a load-use stall.
REQ-028 stall_cycles increments by 1 on each RUN edge where pc_en=0 or pc_sel_redirect=1.
REQ-029 stall_cycles saturates at 16'hFFFF and holds in HALTED.

Reset
REQ-030 nRST low asynchronously forces state RUN, halted 0 and stall_cycles 0.
REQ-031 Assertion of nRST during a stall or in HALTED abandons the stall; the first edge after release evaluates from RUN.

Structure
REQ-032 Type hazard_state_t {RUN, HALTED} and the constant REG_ZERO=5'd0 belong in cpu_types_pkg.
REQ-033 One combinational sub-module, load_use_detect, computes REQ-025 and REQ-027.
REQ-034 The block contains no datapath registers; it drives only the enable and flush inputs of pipeline_reg and the PC mux select.

Verification
REQ-035 Load-use: ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1; stall_cycles +1.
REQ-036 Load to $0: ex_dREN=1, ex_wsel=0, id_rs=0 -> default outputs, no stall.
REQ-037 Redirect during icache miss: mem_redirect=1, ihit=0 -> pc_en=1, pc_sel_redirect=1, ifid, idex and exmem flushed.
REQ-038 Memory stall overrides redirect and load-use: mem_dREN=1, dhit=0, mem_redirect=1 -> pc_en=0, pc_sel_redirect=0, memwb_flush=1.
REQ-039 Halt: wb_halt=1 -> enables 0 that cycle, halted=1 next edge, sticky with wb_halt=0; nRST pulse -> halted=0, stall_cycles=0.
REQ-040 Saturation: 65540 consecutive ihit=0 cycles -> stall_cycles=16'hFFFF.
